// File: rtl/ttl_inverter_pipe.sv
// +----------------------------------------------------------------------------+
// | ttl_inverter_pipe: BLOCKS-wide inverting register pipeline, STAGES deep,   |
// | with a loadable per-bit polarity mask and a fill-valid flag.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module ttl_inverter_pipe #(
    parameter int BLOCKS     = 6,
    parameter int STAGES     = 2,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic              Clk,
    input  logic              Clear_bar,
    input  logic              Enable,
    input  logic              Load_bar,
    input  logic [BLOCKS-1:0] A,
    output logic [BLOCKS-1:0] Y,
    output logic              Valid
);

    localparam int                 c_CNT_W = $clog2(STAGES + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(STAGES);

    if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
        $error("ttl_inverter_pipe: STAGES must be in 1..16");
    end

    logic [STAGES-1:0][BLOCKS-1:0] r_stage;
    logic [BLOCKS-1:0]             r_mask;
    logic [c_CNT_W-1:0]            r_fill;
    logic [BLOCKS-1:0]             w_y;
    logic                          w_valid;

    always_ff @(posedge Clk) begin
        if (!Clear_bar) begin
            r_stage <= '0;
            r_mask  <= '1;
            r_fill  <= '0;
        end else if (!Load_bar) begin
            r_stage <= '0;
            r_mask  <= A;
            r_fill  <= '0;
        end else if (Enable) begin
            r_stage[0] <= A ^ r_mask;
            for (int k = 1; k < STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
            if (r_fill != c_FULL) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    assign w_y     = r_stage[STAGES-1];
    assign w_valid = (r_fill == c_FULL);

    // Separate rise/fall delays: OR of two delayed copies makes the shorter
    // delay govern rising edges; AND makes it govern falling edges.
    if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_nodly
        assign Y     = w_y;
        assign Valid = w_valid;
    end else begin : g_dly
        logic [BLOCKS-1:0] w_y_r;
        logic [BLOCKS-1:0] w_y_f;
        logic              w_v_r;
        logic              w_v_f;

        assign #(DELAY_RISE) w_y_r = w_y;
        assign #(DELAY_FALL) w_y_f = w_y;
        assign #(DELAY_RISE) w_v_r = w_valid;
        assign #(DELAY_FALL) w_v_f = w_valid;

        if (DELAY_RISE < DELAY_FALL) begin : g_slow_fall
            assign Y     = w_y_r | w_y_f;
            assign Valid = w_v_r | w_v_f;
        end else begin : g_slow_rise
            assign Y     = w_y_r & w_y_f;
            assign Valid = w_v_r & w_v_f;
        end
    end

endmodule

`default_nettype wire
